// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 arbitrating multiplexer.
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Modulo-n increment without a divider; the result never reaches n.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority picker: scans req starting at index start, wrapping
// N-1 -> 0, and returns the first requester as one-hot grant plus index.
module rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  // First requester at or after start wins; the first hit locks out the rest.
  always_comb begin
    int               c;
    logic [SEL_W-1:0] cidx;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    cidx  = '0;
    for (int k = 0; k < N; k++) begin
      c = int'(start) + k;
      if (c >= N) c = c - N;
      cidx = c[SEL_W-1:0];
      if (!any && req[cidx]) begin
        any         = 1'b1;
        grant[cidx] = 1'b1;
        idx         = cidx;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 registered multiplexer with fixed-priority or round-robin
// arbitration and a valid/ready handshake on both sides.
module mux_arb_nto1 #(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  parameter  int MODE  = 1,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  import mux_pkg::*;

  logic [SEL_W-1:0] ptr_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] sel_p1;
  logic             vld_p1;

  logic [SEL_W-1:0] start;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] idx;
  logic             any;
  logic             load_en;
  logic             xfer;

  // Fixed priority is the same circular scan anchored at channel 0.
  assign start = (MODE == MODE_RR) ? ptr_p1 : '0;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (in_valid),
    .start (start),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  // The register can take a new beat when empty or being drained this cycle.
  assign load_en  = ~vld_p1 | out_ready;
  // Gate with rst_n so nothing is accepted while reset is held.
  assign in_ready = grant & {N{load_en & rst_n}};
  assign xfer     = any & load_en;

  // ---- stage p1: output register ----
  // Load the winner's word and index; empty the register when drained with no request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
    end else if (load_en) begin
      vld_p1 <= any;
      if (any) begin
        data_p1 <= in_data[int'(idx)*WIDTH +: WIDTH];
        sel_p1  <= idx;
      end
    end
  end

  // Round-robin pointer moves just past the channel that transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_p1 <= '0;
    end else if (xfer && MODE == MODE_RR) begin
      ptr_p1 <= SEL_W'(wrap_inc(int'(idx), N));
    end
  end

  assign out_data  = data_p1;
  assign out_sel   = sel_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Bench for mux_arb_nto1: round-robin N=4, fixed-priority N=4 and
// round-robin N=3 instances sharing one clock and reset.
module tb_mux_arb_nto1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance A: MODE 1, N=4
  logic [31:0] a_data;
  logic [3:0]  a_valid, a_ready;
  logic [7:0]  a_odata;
  logic [1:0]  a_osel;
  logic        a_ovalid, a_ordy;

  // Instance B: MODE 0, N=4
  logic [31:0] b_data;
  logic [3:0]  b_valid, b_ready;
  logic [7:0]  b_odata;
  logic [1:0]  b_osel;
  logic        b_ovalid, b_ordy;

  // Instance C: MODE 1, N=3
  logic [23:0] c_data;
  logic [2:0]  c_valid, c_ready;
  logic [7:0]  c_odata;
  logic [1:0]  c_osel;
  logic        c_ovalid, c_ordy;

  mux_arb_nto1 #(.N(4), .WIDTH(8), .MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .out_data(a_odata), .out_sel(a_osel),
    .out_valid(a_ovalid), .out_ready(a_ordy));

  mux_arb_nto1 #(.N(4), .WIDTH(8), .MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .out_data(b_odata), .out_sel(b_osel),
    .out_valid(b_ovalid), .out_ready(b_ordy));

  mux_arb_nto1 #(.N(3), .WIDTH(8), .MODE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid),
    .in_ready(c_ready), .out_data(c_odata), .out_sel(c_osel),
    .out_valid(c_ovalid), .out_ready(c_ordy));

  typedef struct {
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_ready;
    logic       exp_ovalid;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
  } beat_t;

  vec_t  vecs[17];
  beat_t sb[$];
  beat_t cur;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  function automatic logic [1:0] oh_idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  initial begin
    logic [1:0] e;
    logic [2:0] c_order[4];

    // valid, out_ready, expected in_ready, expected out_valid after the edge
    vecs[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1};
    vecs[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1};
    vecs[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1};
    vecs[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1};
    vecs[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1};
    vecs[5]  = '{4'hF, 1'b0, 4'b0000, 1'b1};
    vecs[6]  = '{4'hF, 1'b0, 4'b0000, 1'b1};
    vecs[7]  = '{4'hF, 1'b0, 4'b0000, 1'b1};
    vecs[8]  = '{4'hF, 1'b1, 4'b0010, 1'b1};
    vecs[9]  = '{4'b1001, 1'b1, 4'b1000, 1'b1};
    vecs[10] = '{4'b1001, 1'b1, 4'b0001, 1'b1};
    vecs[11] = '{4'b1001, 1'b1, 4'b1000, 1'b1};
    vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[14] = '{4'b0100, 1'b0, 4'b0100, 1'b1};
    vecs[15] = '{4'b0100, 1'b0, 4'b0000, 1'b1};
    vecs[16] = '{4'b0010, 1'b1, 4'b0010, 1'b1};

    a_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    c_data = {8'hC2, 8'hC1, 8'hC0};

    // Reset held with every channel requesting
    rst_n   = 1'b0;
    a_valid = 4'hF; b_valid = 4'hF; c_valid = 3'h7;
    a_ordy  = 1'b1; b_ordy  = 1'b1; c_ordy  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ovalid", a_ovalid, 0);
    chk("rst_a_odata",  a_odata,  0);
    chk("rst_a_osel",   a_osel,   0);
    chk("rst_a_ready",  a_ready,  0);
    chk("rst_b_ready",  b_ready,  0);
    chk("rst_c_ready",  c_ready,  0);
    chk("rst_c_ovalid", c_ovalid, 0);

    @(negedge clk);
    rst_n   = 1'b1;
    a_valid = '0; b_valid = '0; c_valid = '0;
    cur = '{2'd0, 8'h00};

    // Table-driven run on instance A with a scoreboard of expected beats
    for (int v = 0; v < 17; v++) begin
      @(negedge clk);
      a_valid = vecs[v].valid;
      a_ordy  = vecs[v].ordy;
      #1;
      chk($sformatf("a_ready[%0d]", v), a_ready, vecs[v].exp_ready);
      if (vecs[v].exp_ready != 4'b0) begin
        e = oh_idx(vecs[v].exp_ready);
        sb.push_back('{e, 8'hA0 + 8'(e)});
      end
      @(posedge clk);
      #1;
      if (sb.size() > 0) cur = sb.pop_front();
      chk($sformatf("a_ovalid[%0d]", v), a_ovalid, vecs[v].exp_ovalid);
      chk($sformatf("a_osel[%0d]", v),   a_osel,   cur.sel);
      chk($sformatf("a_odata[%0d]", v),  a_odata,  cur.data);
    end

    // Instance B: fixed priority keeps channel 0 while it requests
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b_valid = 4'hF; b_ordy = 1'b1;
      #1;
      chk($sformatf("b_ready[%0d]", k), b_ready, 4'b0001);
      @(posedge clk);
      #1;
      chk($sformatf("b_osel[%0d]", k),  b_osel,  0);
      chk($sformatf("b_odata[%0d]", k), b_odata, 8'hA0);
    end
    @(negedge clk);
    b_valid = 4'b1110;
    #1;
    chk("b_ready_no0", b_ready, 4'b0010);
    @(posedge clk);
    #1;
    chk("b_osel_no0", b_osel, 1);
    @(negedge clk);
    b_valid = 4'hF; b_ordy = 1'b0;
    #1;
    chk("b_ready_stall", b_ready, 4'b0000);
    @(negedge clk);
    b_valid = 4'h0;

    // Instance C: lone requester on channel 2, pointer wraps back to 0
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      c_valid = 3'b100; c_ordy = 1'b1;
      #1;
      chk($sformatf("c_lone_ready[%0d]", k), c_ready, 3'b100);
      @(posedge clk);
      #1;
      chk($sformatf("c_lone_sel[%0d]", k),  c_osel,   2);
      chk($sformatf("c_lone_data[%0d]", k), c_odata,  8'hC2);
      chk($sformatf("c_lone_vld[%0d]", k),  c_ovalid, 1);
    end
    c_order[0] = 3'b001; c_order[1] = 3'b010; c_order[2] = 3'b100; c_order[3] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      c_valid = 3'b111;
      #1;
      chk($sformatf("c_all_ready[%0d]", k), c_ready, c_order[k]);
      @(posedge clk);
      #1;
      chk($sformatf("c_all_sel[%0d]", k),  c_osel,  k % 3);
      chk($sformatf("c_all_data[%0d]", k), c_odata, 8'hC0 + 8'(k % 3));
    end
    @(negedge clk);
    c_valid = 3'b000;

    // Reset in the middle of a held beat on A
    @(negedge clk);
    a_valid = 4'hF; a_ordy = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_pre_vld", a_ovalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",   a_ovalid, 0);
    chk("mid_rst_data",  a_odata,  0);
    chk("mid_rst_ready", a_ready,  0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
